// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - Moore control FSM for the subtractive GCD datapath.
// Start/busy/done handshake plus an iteration guard that aborts non-terminating runs.
module gcd_controller #(
   parameter int ITER_W   = 16,
   parameter int MAX_ITER = 1000
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic              x_gt_y,
   input  logic              x_lt_y,
   output logic              sel_x,
   output logic              sel_y,
   output logic              sel_sub,
   output logic              ld_x,
   output logic              ld_y,
   output logic              ld_obeb,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [ITER_W-1:0] iter_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CMP   = 3'd2,
      S_SUBX  = 3'd3,
      S_SUBY  = 3'd4,
      S_STORE = 3'd5,
      S_DONE  = 3'd6,
      S_ABORT = 3'd7
   } state_t;

   localparam logic [ITER_W-1:0] MAX_C = ITER_W'(MAX_ITER);

   state_t            state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              iter_max;

   assign iter_max   = (iter_q == MAX_C);
   assign iter_count = iter_q;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
      end
   end

   // A gt+lt flag pair is illegal; it falls into the x_gt_y branch by priority.
   always_comb begin
      state_d = S_IDLE;
      iter_d  = iter_q;
      case (state_q)
         S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
         S_LOAD: begin
            iter_d  = '0;
            state_d = S_CMP;
         end
         S_CMP: begin
            if (x_gt_y)      state_d = iter_max ? S_ABORT : S_SUBX;
            else if (x_lt_y) state_d = iter_max ? S_ABORT : S_SUBY;
            else             state_d = S_STORE;
         end
         S_SUBX, S_SUBY: begin
            iter_d  = iter_max ? iter_q : iter_q + 1'b1;
            state_d = S_CMP;
         end
         S_STORE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sel_x   = 1'b0;
      sel_y   = 1'b0;
      sel_sub = 1'b0;
      ld_x    = 1'b0;
      ld_y    = 1'b0;
      ld_obeb = 1'b0;
      busy    = (state_q != S_IDLE);
      done    = 1'b0;
      timeout = 1'b0;
      case (state_q)
         S_LOAD: begin
            ld_x = 1'b1;
            ld_y = 1'b1;
         end
         S_SUBX: begin
            sel_x = 1'b1;
            ld_x  = 1'b1;
         end
         S_SUBY: begin
            sel_sub = 1'b1;
            sel_y   = 1'b1;
            ld_y    = 1'b1;
         end
         S_STORE: ld_obeb = 1'b1;
         S_DONE:  done    = 1'b1;
         S_ABORT: timeout = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gcd_controller.sv
// tb/tb_gcd_controller.sv - Directed bench for gcd_controller with a behavioural datapath.
// Expected results are queued at stimulus time and popped when done/timeout fires.
module tb_gcd_controller;

   localparam int ITER_W   = 16;
   localparam int MAX_ITER = 4;

   logic              CLK = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              x_gt_y, x_lt_y;
   logic              sel_x, sel_y, sel_sub, ld_x, ld_y, ld_obeb;
   logic              busy, done, timeout;
   logic [ITER_W-1:0] iter_count;

   logic [31:0] xi = '0, yi = '0;
   logic [31:0] x_r = '0, y_r = '0, obeb = '0;
   logic [31:0] sub_res;

   typedef struct {
      logic [31:0] res;
      int          iter;
      logic        to;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_res = '0;
   int          n_total = 0;
   int          n_pass = 0;

   gcd_controller #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
      .CLK(CLK), .reset(reset), .start(start), .x_gt_y(x_gt_y), .x_lt_y(x_lt_y),
      .sel_x(sel_x), .sel_y(sel_y), .sel_sub(sel_sub), .ld_x(ld_x), .ld_y(ld_y),
      .ld_obeb(ld_obeb), .busy(busy), .done(done), .timeout(timeout),
      .iter_count(iter_count)
   );

   always #5 CLK = ~CLK;

   // Neighbouring datapath: not touched by reset.
   assign sub_res = sel_sub ? (y_r - x_r) : (x_r - y_r);
   assign x_gt_y  = (x_r > y_r);
   assign x_lt_y  = (x_r < y_r);
   always @(posedge CLK) begin
      if (ld_x)    x_r  <= sel_x ? sub_res : xi;
      if (ld_y)    y_r  <= sel_y ? sub_res : yi;
      if (ld_obeb) obeb <= x_r;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   n = 0;
      e.to = 1'b0;
      while (a != b) begin
         if (n == MAX_ITER) begin
            e.to = 1'b1;
            break;
         end
         if (a > b) a = a - b;
         else       b = b - a;
         n++;
      end
      e.iter = n;
      e.res  = e.to ? last_res : a;
      e.lat  = e.to ? 2 * n + 3 : 2 * n + 4;
      if (!e.to) last_res = a;
      return e;
   endfunction

   always @(negedge CLK) begin
      if (!reset && (done || timeout)) begin
         if (sb.size() == 0) begin
            check("unexpected_end", 32'(sb.size()), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_timeout_excl", 32'(done && timeout), 0);
            check("timeout_flag", 32'(timeout), 32'(e.to));
            check("iter_count", 32'(iter_count), 32'(e.iter));
            check("obeb", obeb, e.res);
         end
      end
   end

   task automatic run(input logic [31:0] a, input logic [31:0] b, input bit poke);
      exp_t e;
      int   cyc;
      e = model(a, b);
      sb.push_back(e);
      xi = a;
      yi = b;
      start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      @(negedge CLK);
      check("busy_rise", 32'(busy), 1);
      cyc = 1;
      while (!(done || timeout) && cyc < 300) begin
         start = (poke && cyc == 2);
         @(negedge CLK);
         cyc++;
      end
      start = 1'b0;
      check("latency", cyc, e.lat);
      @(negedge CLK);
      check("busy_fall", 32'(busy), 0);
      if (poke) begin
         @(negedge CLK);
         check("poke_ignored", 32'(busy), 0);
      end
   endtask

   initial begin
      int   cyc;
      exp_t e;
      repeat (2) @(negedge CLK);
      check("reset_outputs", 32'({sel_x, sel_y, sel_sub, ld_x, ld_y, ld_obeb, busy, done, timeout}), 0);
      check("reset_iter", 32'(iter_count), 0);
      reset = 1'b0;
      @(negedge CLK);
      check("idle_busy", 32'(busy), 0);

      run(32'd12, 32'd8, 1'b0);
      run(32'd7,  32'd7, 1'b0);
      run(32'd0,  32'd5, 1'b0);
      run(32'd0,  32'd0, 1'b0);
      run(32'd5,  32'd1, 1'b0);
      run(32'd6,  32'd1, 1'b0);

      // Reset during the SUBY step of a 35/21 run
      xi = 32'd35;
      yi = 32'd21;
      start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      cyc = 0;
      while (!sel_y && cyc < 50) begin
         @(negedge CLK);
         cyc++;
      end
      check("reached_suby", 32'(sel_y), 1);
      #2 reset = 1'b1;
      #1;
      check("midrun_reset_outputs", 32'({sel_x, sel_y, sel_sub, ld_x, ld_y, ld_obeb, busy, done, timeout}), 0);
      check("midrun_reset_iter", 32'(iter_count), 0);
      @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      run(32'd35, 32'd21, 1'b0);

      // Start held high: three back-to-back runs
      xi = 32'd9;
      yi = 32'd6;
      for (int k = 0; k < 3; k++) sb.push_back(model(32'd9, 32'd6));
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc = 0;
         while (!done && cyc < 300) begin
            @(negedge CLK);
            cyc++;
         end
         check("held_done", 32'(done), 1);
         if (k == 2) start = 1'b0;
         @(negedge CLK);
         check("held_idle", 32'(busy), 0);
         if (k < 2) begin
            @(negedge CLK);
            check("held_reload", 32'(ld_x && ld_y), 1);
         end
      end
      @(negedge CLK);
      check("held_stop", 32'(busy), 0);

      run(32'd21, 32'd14, 1'b1);
      run(32'd0,  32'd3,  1'b1);

      repeat (3) @(negedge CLK);
      check("scoreboard_empty", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
